// File: rtl/dm_bytelane.sv
// Byte-lane data memory: byte/half/word stores and loads with sign/zero
// extension, registered read data with a valid strobe, and a clear sequence after reset.
module dm_bytelane #(
  parameter int DEPTH      = 64,
  parameter int ADDR_W     = 8,
  parameter bit INIT_CLEAR = 1'b1
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Ad,
  input  logic [31:0]       WrData,
  input  logic              DMWr,
  input  logic              DMRd,
  input  logic [1:0]        Size,
  input  logic              Unsigned,
  output logic [31:0]       DM,
  output logic              DMValid,
  output logic              AlignErr,
  output logic              Busy
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [0:0] INIT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state_p0;
  logic [IDX_W-1:0] cnt_p0;
  logic [31:0]      mem [DEPTH];

  logic [IDX_W-1:0] idx;
  logic             run;
  logic             legal;
  logic             wr_go;
  logic             rd_go;
  logic             err;
  logic [3:0]       wr_en;
  logic [31:0]      wr_lanes;

  function automatic logic is_legal(input logic [1:0] sz, input logic [1:0] lane);
    logic ok;
    case (sz)
      2'b00:   ok = 1'b1;
      2'b01:   ok = ~lane[0];
      2'b10:   ok = (lane == 2'b00);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic [3:0] lane_en(input logic [1:0] sz, input logic [1:0] lane);
    logic [3:0] en;
    case (sz)
      2'b00:   en = 4'b0001 << lane;
      2'b01:   en = lane[1] ? 4'b1100 : 4'b0011;
      default: en = 4'b1111;
    endcase
    return en;
  endfunction

  // Store data is right-aligned; replicate it so every candidate lane sees it.
  function automatic logic [31:0] lane_data(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] r;
    case (sz)
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] sz,
                                           input logic [1:0] lane, input logic uns);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] ext;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (sz)
      2'b00:   ext = uns ? {24'b0, b} : 32'(b);
      2'b01:   ext = uns ? {16'b0, h} : 32'(h);
      default: ext = w;
    endcase
    return ext;
  endfunction

  assign idx      = Ad[ADDR_W-1:2];
  assign run      = (state_p0 == RUN);
  assign legal    = is_legal(Size, Ad[1:0]);
  assign wr_go    = run & DMWr & legal;
  assign rd_go    = run & DMRd & legal;
  assign err      = run & (DMWr | DMRd) & ~legal;
  assign wr_en    = lane_en(Size, Ad[1:0]);
  assign wr_lanes = lane_data(Size, WrData);
  assign Busy     = ~run;

  // Stage p0 -> array: clear sweep while initialising, lane-masked stores after.
  always_ff @(posedge Clk) begin
    if (!run) begin
      mem[cnt_p0] <= '0;
    end else if (wr_go) begin
      for (int l = 0; l < 4; l++) begin
        if (wr_en[l]) mem[idx][8*l +: 8] <= wr_lanes[8*l +: 8];
      end
    end
  end

  // Stage p0 -> p1: registered load result, strobes and clear sequencing.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_p0 <= INIT_CLEAR ? INIT : RUN;
      cnt_p0   <= '0;
      DM       <= '0;
      DMValid  <= 1'b0;
      AlignErr <= 1'b0;
    end else begin
      DMValid  <= rd_go;
      AlignErr <= err;
      if (rd_go) DM <= load_ext(mem[idx], Size, Ad[1:0], Unsigned);
      if (!run) begin
        cnt_p0 <= cnt_p0 + 1'b1;
        if (cnt_p0 == IDX_W'(DEPTH - 1)) state_p0 <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_dm_bytelane.sv
// Bench for dm_bytelane: directed scenarios plus random traffic against a byte-array model.
module tb_dm_bytelane;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 8;
  localparam int NB     = DEPTH * 4;

  logic              Clk = 1'b0;
  logic              Reset_n = 1'b0;
  logic [ADDR_W-1:0] Ad = '0;
  logic [31:0]       WrData = '0;
  logic              DMWr = 1'b0;
  logic              DMRd = 1'b0;
  logic [1:0]        Size = 2'b00;
  logic              Unsigned = 1'b0;
  logic [31:0]       DM;
  logic              DMValid;
  logic              AlignErr;
  logic              Busy;

  dm_bytelane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INIT_CLEAR(1'b1)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Ad(Ad), .WrData(WrData), .DMWr(DMWr), .DMRd(DMRd),
    .Size(Size), .Unsigned(Unsigned), .DM(DM), .DMValid(DMValid), .AlignErr(AlignErr),
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [7:0]  mem_m [NB];
  logic [31:0] dm_m;
  int          busy_left;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit legal_m(input int sz, input int a);
    return (sz == 0) || (sz == 1 && a % 2 == 0) || (sz == 2 && a % 4 == 0);
  endfunction

  function automatic logic [31:0] read_m(input int sz, input int a, input bit uns);
    int v;
    int base;
    case (sz)
      0: begin
        v = int'(mem_m[a]);
        if (!uns && v >= 128) v -= 256;
      end
      1: begin
        base = (a / 2) * 2;
        v = int'(mem_m[base]) + 256 * int'(mem_m[base + 1]);
        if (!uns && v >= 32768) v -= 65536;
      end
      default: begin
        base = (a / 4) * 4;
        return {mem_m[base + 3], mem_m[base + 2], mem_m[base + 1], mem_m[base]};
      end
    endcase
    return 32'(v);
  endfunction

  task automatic write_m(input int sz, input int a, input logic [31:0] wd);
    int base;
    int n;
    n    = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    base = (a / n) * n;
    for (int k = 0; k < n; k++) mem_m[base + k] = wd[8*k +: 8];
  endtask

  task automatic op(input bit wr, input bit rd, input int sz, input int a,
                    input logic [31:0] wd, input bit uns, input string tag);
    bit lg;
    bit v_e;
    bit e_e;
    lg  = legal_m(sz, a);
    v_e = 1'b0;
    e_e = 1'b0;
    if (busy_left == 0) begin
      if (rd && lg) begin
        dm_m = read_m(sz, a, uns);
        v_e  = 1'b1;
      end
      e_e = (wr || rd) && !lg;
      if (wr && lg) write_m(sz, a, wd);
    end
    DMWr = wr; DMRd = rd; Size = 2'(sz); Ad = ADDR_W'(a); WrData = wd; Unsigned = uns;
    @(posedge Clk);
    #1;
    if (busy_left > 0) busy_left--;
    chk({tag, ".valid"}, 32'(DMValid), 32'(v_e));
    chk({tag, ".alignerr"}, 32'(AlignErr), 32'(e_e));
    chk({tag, ".dm"}, DM, dm_m);
    chk({tag, ".busy"}, 32'(Busy), 32'(busy_left > 0));
    DMWr = 1'b0; DMRd = 1'b0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NB; i++) mem_m[i] = 8'h00;
    dm_m      = '0;
    busy_left = DEPTH;
  endtask

  task automatic do_reset(input string tag);
    @(posedge Clk);
    #3;
    Reset_n = 1'b0;
    #1;
    chk({tag, ".dm"}, DM, 32'h0);
    chk({tag, ".valid"}, 32'(DMValid), 32'h0);
    chk({tag, ".alignerr"}, 32'(AlignErr), 32'h0);
    chk({tag, ".busy"}, 32'(Busy), 32'h1);
    DMRd = 1'b1; DMWr = 1'b1;
    @(posedge Clk);
    #1;
    chk({tag, ".held_valid"}, 32'(DMValid), 32'h0);
    chk({tag, ".held_dm"}, DM, 32'h0);
    DMRd = 1'b0; DMWr = 1'b0;
    Reset_n = 1'b1;
    clear_model();
  endtask

  initial begin
    int busy_cycles;
    repeat (2) @(posedge Clk);
    #1;
    chk("por.dm", DM, 32'h0);
    chk("por.valid", 32'(DMValid), 32'h0);
    chk("por.alignerr", 32'(AlignErr), 32'h0);
    chk("por.busy", 32'(Busy), 32'h1);
    Reset_n = 1'b1;
    clear_model();

    op(0, 1, 2, 'h00, 32'h0, 0, "busy_rd");
    op(1, 0, 2, 'h10, 32'hDEADBEEF, 0, "busy_wr");
    op(0, 1, 1, 'h11, 32'h0, 0, "busy_misal");
    busy_cycles = 3;
    while (busy_left > 0 && busy_cycles < 200) begin
      op(0, 0, 0, 0, 32'h0, 0, "init");
      busy_cycles++;
    end
    chk("init.len", 32'(busy_cycles), 32'(DEPTH));

    op(0, 1, 2, 'h00, 32'h0, 0, "rd0");
    chk("rd0.const", DM, 32'h0000_0000);
    op(0, 1, 2, 'h10, 32'h0, 0, "rd10_cleared");
    op(1, 0, 2, 'h10, 32'h8899AABB, 0, "st_w");
    op(1, 0, 0, 'h12, 32'h0000007F, 0, "st_b");
    op(0, 1, 2, 'h10, 32'h0, 0, "ld_w");
    chk("ld_w.const", DM, 32'h887FAABB);
    op(0, 1, 0, 'h13, 32'h0, 0, "ld_bs");
    chk("ld_bs.const", DM, 32'hFFFFFF88);
    op(0, 1, 0, 'h13, 32'h0, 1, "ld_bu");
    chk("ld_bu.const", DM, 32'h00000088);
    op(0, 1, 1, 'h12, 32'h0, 0, "ld_hs");
    chk("ld_hs.const", DM, 32'hFFFF887F);
    op(0, 1, 1, 'h12, 32'h0, 1, "ld_hu");
    chk("ld_hu.const", DM, 32'h0000887F);
    op(1, 0, 1, 'h11, 32'h00005555, 0, "misal_st");
    op(0, 1, 2, 'h16, 32'h0, 0, "misal_ld");
    op(0, 1, 3, 'h10, 32'h0, 0, "size11");
    op(0, 1, 2, 'h10, 32'h0, 0, "ld_w2");
    chk("ld_w2.const", DM, 32'h887FAABB);
    op(1, 1, 2, 'h20, 32'h12345678, 0, "rbw");
    chk("rbw.const", DM, 32'h00000000);
    op(0, 1, 2, 'h20, 32'h0, 0, "rbw_after");
    chk("rbw_after.const", DM, 32'h12345678);
    op(1, 0, 2, 'hFC, 32'hCAFEF00D, 0, "top_st");
    op(0, 1, 1, 'hFE, 32'h0, 0, "top_ld");
    chk("top_ld.const", DM, 32'hFFFFCAFE);

    for (int i = 0; i < 600; i++) begin
      op(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)), $urandom_range(0, 3),
         $urandom_range(0, NB - 1), $urandom, bit'($urandom_range(0, 1)), "rnd");
    end
    op(0, 1, 2, 'h20, 32'h0, 0, "pre_rst");

    do_reset("rst1");
    for (int i = 0; i < 30; i++) op(0, 0, 0, 0, 32'h0, 0, "init2");
    do_reset("rst_mid");
    busy_cycles = 0;
    while (busy_left > 0 && busy_cycles < 200) begin
      op(0, 1, 2, 'h10, 32'h0, 0, "init3");
      busy_cycles++;
    end
    chk("init3.len", 32'(busy_cycles), 32'(DEPTH));
    op(0, 1, 2, 'h10, 32'h0, 0, "post_clear");
    chk("post_clear.const", DM, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
